// File: rtl/mem_access_ctrl_if.sv
// Load/store unit bus: control-unit side inputs, data-memory port and
// write-back side outputs of mem_access_ctrl.
interface mem_access_ctrl_if;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write_in;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        stall;
    logic        mem_to_reg;
    logic [31:0] load_data;
    logic        reg_write_en;
    logic        misalign_err;
    logic        bus_err;

    modport slave (
        input  mem_read, mem_write, reg_write_in, funct3, addr, store_data,
               mem_ready, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall,
               mem_to_reg, load_data, reg_write_en, misalign_err, bus_err
    );

    modport master (
        output mem_read, mem_write, reg_write_in, funct3, addr, store_data,
               mem_ready, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be, stall,
               mem_to_reg, load_data, reg_write_en, misalign_err, bus_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller: stalls the pipeline while a data-memory access is
// in flight, formats load data, flags misaligned accesses and bus timeouts.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;

    logic          req_q, we_q, mis_q, berr_q;
    logic [31:0]   addr_q, wdata_q, ld_q;
    logic [3:0]    be_q;

    logic          stall_c, m2r_c, rwe_c;
    logic          is_req, aligned, is_store, timeout_hit;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;

    // Size/sign formatting of the raw memory word for loads.
    function automatic logic [31:0] fmt_load(input logic [2:0] f3,
                                             input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = 16'(w >> {off[1], 4'b0000});
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    assign is_req      = bus.mem_read | bus.mem_write;
    // A load wins when both are requested.
    assign is_store    = bus.mem_write & ~bus.mem_read;
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // Alignment check and store lane placement; undefined sizes act as word.
    always_comb begin
        aligned  = 1'b1;
        st_be    = 4'b1111;
        st_wdata = bus.store_data;
        case (bus.funct3)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~bus.addr[0];
            default:        aligned = (bus.addr[1:0] == 2'b00);
        endcase
        case (bus.funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << bus.addr[1:0];
                st_wdata = {4{bus.store_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << {bus.addr[1], 1'b0};
                st_wdata = {2{bus.store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = bus.store_data;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and pipeline-facing combinational controls.
    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        m2r_c     = 1'b0;
        rwe_c     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    rwe_c = bus.reg_write_in;
                    if (is_req) begin
                        stall_c   = 1'b1;
                        rwe_c     = 1'b0;
                        state_nxt = aligned ? ACCESS : DONE;
                    end
                end
                ACCESS: begin
                    stall_c = 1'b1;
                    if (bus.mem_ready || timeout_hit) state_nxt = DONE;
                end
                DONE: begin
                    m2r_c     = bus.mem_read;
                    rwe_c     = bus.reg_write_in & bus.mem_read & ~mis_q & ~berr_q;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Memory request registers, wait counter, load result and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ld_q    <= '0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            mis_q  <= 1'b0;
            berr_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_req) begin
                        if (aligned) begin
                            cnt     <= '0;
                            f3_q    <= bus.funct3;
                            off_q   <= bus.addr[1:0];
                            req_q   <= 1'b1;
                            we_q    <= is_store;
                            addr_q  <= {bus.addr[31:2], 2'b00};
                            wdata_q <= is_store ? st_wdata : 32'h0;
                            be_q    <= is_store ? st_be : 4'b1111;
                        end else begin
                            mis_q <= 1'b1;
                            ld_q  <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.mem_ready) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (!we_q) ld_q <= fmt_load(f3_q, off_q, bus.mem_rdata);
                    end else if (timeout_hit) begin
                        req_q  <= 1'b0;
                        we_q   <= 1'b0;
                        berr_q <= 1'b1;
                        ld_q   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_req      = req_q;
    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_be       = be_q;
    assign bus.load_data    = ld_q;
    assign bus.misalign_err = mis_q;
    assign bus.bus_err      = berr_q;
    assign bus.stall        = stall_c;
    assign bus.mem_to_reg   = m2r_c;
    assign bus.reg_write_en = rwe_c;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with hand-computed expectations.
module tb_mem_access_ctrl;
    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.reg_write_in = 1'b0;
        bus.funct3       = 3'b010;
        bus.addr         = 32'h0;
        bus.store_data   = 32'h0;
        bus.mem_ready    = 1'b0;
        bus.mem_rdata    = 32'h0;
    endtask

    // Present a memory instruction in IDLE, check the stall, advance one edge.
    task automatic start_op(input string tag, input logic rd, input logic wr,
                            input logic rwin, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd);
        bus.mem_read     = rd;
        bus.mem_write    = wr;
        bus.reg_write_in = rwin;
        bus.funct3       = f3;
        bus.addr         = a;
        bus.store_data   = sd;
        #1;
        chk({tag, ".idle_stall"}, 32'(bus.stall), 32'd1);
        chk({tag, ".idle_rwe"}, 32'(bus.reg_write_en), 32'd0);
        tick();
    endtask

    // In ACCESS: answer with rdata this cycle, land in DONE.
    task automatic respond(input logic [31:0] rdata);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        bus.mem_ready = 1'b0;
        #1;
    endtask

    // Leave DONE and return to IDLE with no instruction pending.
    task automatic finish_op();
        idle_inputs();
        tick();
    endtask

    task automatic load_fmt(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rdata, input logic [31:0] exp);
        start_op(tag, 1'b1, 1'b0, 1'b1, f3, a, 32'h0);
        respond(rdata);
        chk({tag, ".load_data"}, bus.load_data, exp);
        chk({tag, ".rwe"}, 32'(bus.reg_write_en), 32'd1);
        finish_op();
    endtask

    initial begin
        int n;
        idle_inputs();
        rst = 1'b1;
        // Reset with a load and reg write presented: comb outputs held low.
        bus.mem_read     = 1'b1;
        bus.reg_write_in = 1'b1;
        tick();
        tick();
        chk("rst.stall", 32'(bus.stall), 32'd0);
        chk("rst.rwe", 32'(bus.reg_write_en), 32'd0);
        chk("rst.m2r", 32'(bus.mem_to_reg), 32'd0);
        chk("rst.mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst.load_data", bus.load_data, 32'h0);
        chk("rst.mem_be", 32'(bus.mem_be), 32'h0);
        idle_inputs();
        rst = 1'b0;
        tick();

        // ALU instruction passes straight through; mem_ready in IDLE ignored.
        bus.reg_write_in = 1'b1;
        bus.mem_ready    = 1'b1;
        #1;
        chk("alu.stall", 32'(bus.stall), 32'd0);
        chk("alu.m2r", 32'(bus.mem_to_reg), 32'd0);
        chk("alu.rwe", 32'(bus.reg_write_en), 32'd1);
        tick();
        chk("alu.mem_req", 32'(bus.mem_req), 32'd0);
        chk("alu.stall2", 32'(bus.stall), 32'd0);
        idle_inputs();

        // LW 0x100, memory answers in the first ACCESS cycle.
        start_op("lw", 1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'h0);
        chk("lw.mem_req", 32'(bus.mem_req), 32'd1);
        chk("lw.mem_we", 32'(bus.mem_we), 32'd0);
        chk("lw.mem_addr", bus.mem_addr, 32'h100);
        chk("lw.mem_be", 32'(bus.mem_be), 32'hF);
        chk("lw.mem_wdata", bus.mem_wdata, 32'h0);
        chk("lw.acc_stall", 32'(bus.stall), 32'd1);
        respond(32'hDEADBEEF);
        chk("lw.done_stall", 32'(bus.stall), 32'd0);
        chk("lw.load_data", bus.load_data, 32'hDEADBEEF);
        chk("lw.m2r", 32'(bus.mem_to_reg), 32'd1);
        chk("lw.rwe", 32'(bus.reg_write_en), 32'd1);
        chk("lw.req_drop", 32'(bus.mem_req), 32'd0);
        finish_op();

        load_fmt("lb",  3'b000, 32'h103, 32'h80112233, 32'hFFFFFF80);
        load_fmt("lbu", 3'b100, 32'h103, 32'h80112233, 32'h00000080);
        load_fmt("lhu", 3'b101, 32'h102, 32'h80112233, 32'h00008011);
        load_fmt("lh",  3'b001, 32'h102, 32'h80112233, 32'hFFFF8011);
        load_fmt("lb0", 3'b000, 32'h100, 32'h80112233, 32'h00000033);

        // SH 0x202 with two wait cycles; request must stay stable.
        start_op("sh", 1'b0, 1'b1, 1'b0, 3'b001, 32'h202, 32'h0000ABCD);
        chk("sh.mem_addr", bus.mem_addr, 32'h200);
        chk("sh.mem_be", 32'(bus.mem_be), 32'hC);
        chk("sh.mem_wdata", bus.mem_wdata, 32'hABCDABCD);
        chk("sh.mem_we", 32'(bus.mem_we), 32'd1);
        tick();
        tick();
        chk("sh.hold_req", 32'(bus.mem_req), 32'd1);
        chk("sh.hold_be", 32'(bus.mem_be), 32'hC);
        chk("sh.hold_stall", 32'(bus.stall), 32'd1);
        respond(32'h0);
        chk("sh.rwe", 32'(bus.reg_write_en), 32'd0);
        chk("sh.m2r", 32'(bus.mem_to_reg), 32'd0);
        chk("sh.we_drop", 32'(bus.mem_we), 32'd0);
        chk("sh.load_keep", bus.load_data, 32'h00000033);
        finish_op();

        // SB 0x201.
        start_op("sb", 1'b0, 1'b1, 1'b0, 3'b000, 32'h201, 32'h1234565A);
        chk("sb.mem_be", 32'(bus.mem_be), 32'h2);
        chk("sb.mem_wdata", bus.mem_wdata, 32'h5A5A5A5A);
        respond(32'h0);
        finish_op();

        // Load and store together execute as a load.
        start_op("ldst", 1'b1, 1'b1, 1'b1, 3'b010, 32'h400, 32'hFFFFFFFF);
        chk("ldst.mem_we", 32'(bus.mem_we), 32'd0);
        chk("ldst.mem_wdata", bus.mem_wdata, 32'h0);
        respond(32'hCAFEF00D);
        chk("ldst.load_data", bus.load_data, 32'hCAFEF00D);
        chk("ldst.m2r", 32'(bus.mem_to_reg), 32'd1);
        finish_op();

        // Misaligned LW 0x101.
        start_op("mis", 1'b1, 1'b0, 1'b1, 3'b010, 32'h101, 32'h0);
        chk("mis.mem_req", 32'(bus.mem_req), 32'd0);
        chk("mis.err", 32'(bus.misalign_err), 32'd1);
        chk("mis.rwe", 32'(bus.reg_write_en), 32'd0);
        chk("mis.stall", 32'(bus.stall), 32'd0);
        chk("mis.load_data", bus.load_data, 32'h0);
        finish_op();
        chk("mis.pulse_end", 32'(bus.misalign_err), 32'd0);

        // Timeout: mem_ready never comes.
        start_op("to", 1'b1, 1'b0, 1'b1, 3'b010, 32'h300, 32'h0);
        n = 0;
        while (bus.mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("to.req_cycles", 32'(n), 32'd15);
        chk("to.bus_err", 32'(bus.bus_err), 32'd1);
        chk("to.load_data", bus.load_data, 32'h0);
        chk("to.rwe", 32'(bus.reg_write_en), 32'd0);
        finish_op();
        chk("to.pulse_end", 32'(bus.bus_err), 32'd0);

        // mem_ready on the last allowed ACCESS cycle is a completion.
        start_op("edge", 1'b1, 1'b0, 1'b1, 3'b010, 32'h304, 32'h0);
        repeat (14) tick();
        chk("edge.req_last", 32'(bus.mem_req), 32'd1);
        respond(32'h12345678);
        chk("edge.bus_err", 32'(bus.bus_err), 32'd0);
        chk("edge.load_data", bus.load_data, 32'h12345678);
        chk("edge.rwe", 32'(bus.reg_write_en), 32'd1);
        finish_op();

        // Reset in the middle of ACCESS.
        start_op("rmid", 1'b1, 1'b0, 1'b1, 3'b010, 32'h500, 32'h0);
        tick();
        chk("rmid.req_before", 32'(bus.mem_req), 32'd1);
        idle_inputs();
        rst = 1'b1;
        tick();
        chk("rmid.mem_req", 32'(bus.mem_req), 32'd0);
        chk("rmid.mem_addr", bus.mem_addr, 32'h0);
        chk("rmid.load_data", bus.load_data, 32'h0);
        chk("rmid.stall", 32'(bus.stall), 32'd0);
        rst = 1'b0;
        bus.reg_write_in = 1'b1;
        #1;
        chk("rmid.idle_rwe", 32'(bus.reg_write_en), 32'd1);
        chk("rmid.idle_stall", 32'(bus.stall), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: max ACCESS-state cycles awaiting mem_ready before abort.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 mem_read  input  1  current instruction is a load (control unit).
REQ-005 mem_write  input  1  current instruction is a store (control unit).
REQ-006 reg_write_in  input  1  control-unit register write enable for current instruction.
REQ-007 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  ALU result, byte address.
REQ-009 store_data  input  32  rs2 value for stores.
REQ-010 mem_ready  input  1  data memory completes current request.
REQ-011 mem_rdata  input  32  data memory read word, valid when mem_ready=1.
REQ-012 mem_req, mem_we  output  1 each  registered request / write-enable to data memory.
REQ-013 mem_addr  output  32  registered word address, addr with bits [1:0] cleared.
REQ-014 mem_wdata  output  32  registered store data, lane-replicated; mem_be  output  4  byte enables.
REQ-015 stall  output  1  combinational; holds PC/instruction while high.
REQ-016 mem_to_reg  output  1  write-back mux select (1 = load_data, 0 = ALU result).
REQ-017 load_data  output  32  registered, size/sign-formatted load result.
REQ-018 reg_write_en  output  1  gated register-file write enable.
REQ-019 misalign_err, bus_err  output  1 each  one-cycle error pulses.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, DONE.
REQ-021 IDLE, mem_read=mem_write=0: stall=0, mem_to_reg=0, reg_write_en=reg_write_in, no state change.
REQ-022 IDLE, mem_read|mem_write, aligned: stall=1, reg_write_en=0; next cycle ACCESS with mem_req=1, mem_we=mem_write&~mem_read, addr/wdata/be latched.
REQ-023 Both mem_read and mem_write high: SHALL execute as load; write ignored.
REQ-024 Alignment: H/HU need addr[0]=0; W needs addr[1:0]=00; B always aligned; undefined funct3 treated as W.
REQ-025 Misaligned request in IDLE: no mem_req; next state DONE; misalign_err=1 for the DONE cycle; load_data=0; reg_write_en=0 in DONE.
REQ-026 Store lanes: SB be=0001<<addr[1:0], wdata={4{sd[7:0]}}; SH be=0011<<{addr[1],0}, wdata={2{sd[15:0]}}; SW be=1111, wdata=sd.
REQ-027 Loads: mem_be=1111; mem_wdata=0.
REQ-028 ACCESS: stall=1; mem_req, mem_we, mem_addr, mem_wdata, mem_be SHALL stay stable until exit; wait counter increments each cycle.
REQ-029 ACCESS with mem_ready=1: capture formatted mem_rdata into load_data (loads only), deassert mem_req, go DONE; minimum latency IDLE->DONE = 2 cycles.
REQ-030 Load format: B/BU select byte addr[1:0], H/HU half addr[1]; B/H sign-extend, BU/HU zero-extend.
REQ-031 Counter reaching TIMEOUT without mem_ready: abort, mem_req=0, load_data=0, bus_err=1 during DONE, reg_write_en=0 in DONE.
REQ-032 mem_ready arriving on the TIMEOUT cycle SHALL count as completion (no bus_err).
REQ-033 DONE (exactly one cycle): stall=0, mem_to_reg=mem_read, reg_write_en=reg_write_in&mem_read unless error; next state IDLE unconditionally.
REQ-034 mem_ready while not in ACCESS SHALL be ignored.
REQ-035 Counter SHALL clear on entry to ACCESS; width ceil(log2(TIMEOUT+1)).

Reset
REQ-036 rst=1 at a clock edge SHALL force IDLE, counter=0, load_data=0, mem_req=mem_we=0, mem_addr=mem_wdata=0, mem_be=0, error pulses 0, from any state including mid-ACCESS.
REQ-037 Combinational outputs during rst SHALL be stall=0, reg_write_en=0, mem_to_reg=0.

Verification
REQ-038 LW addr=0x100, mem_ready one cycle after mem_req, rdata=0xDEADBEEF -> stall 2 cycles, DONE: load_data=0xDEADBEEF, mem_to_reg=1, reg_write_en=1.
REQ-039 LB addr=0x103, rdata=0x80112233 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x102 -> 0x00008011.
REQ-040 SH addr=0x202, store_data=0x0000ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, reg_write_en=0.
REQ-041 LW addr=0x101 -> no mem_req, misalign_err pulse, reg_write_en=0, stall released after 1 cycle.
REQ-042 mem_ready held 0, TIMEOUT=15 -> mem_req high 15 cycles, bus_err pulse, load_data=0; rst asserted mid-ACCESS -> IDLE, mem_req=0 next edge.
REQ-043 ALU instruction (mem_read=mem_write=0, reg_write_in=1) -> stall=0, mem_to_reg=0, reg_write_en=1 same cycle.
